uart_tx_arbiter: RTL and testbench

//  Shares one UART byte transmitter among N_REQ byte-stream requesters (e.g. debug

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART arbitration types and constants.
// No logic; pure definitions.
// No flow control here.
package uart_pkg;

  // Arbiter FSM: pick a requester, wait for the transmitter to start, wait for it to finish.
  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_IDLE = 2'd2
  } arb_state_t;

  localparam int UART_BAUD = 115200;
  localparam int CLK_HZ    = 50_000_000;

  // Clock cycles per UART bit for a given clock and baud rate.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way round-robin picker: first set request after the pointer.
// Zero latency (pure combinational).
// No backpressure; the caller decides when the pick is used.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan ptr+1, ptr+2, ... modulo N; the pointer itself is checked last.
  always_comb begin
    int            j;
    logic [IW-1:0] w_j;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    j        = 0;
    w_j      = '0;
    for (int k = 1; k <= N; k++) begin
      j   = (int'(i_ptr) + k) % N;
      w_j = IW'(j);
      if (!o_any && i_req[w_j]) begin
        o_any         = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART byte transmitter among N_REQ packet requesters.
// VALID->TX_DV one cycle; next issue only after the transmitter returns to idle.
// Requesters hold VALID until a one-cycle REQ_READY; a packet owner keeps the grant until LAST or timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int LOCK_TIMEOUT = 1200,
  parameter int BUSY_GUARD   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_last,
  input  logic [8*N_REQ-1:0] i_req_byte,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_dv,
  output logic [7:0]         o_tx_byte,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_tx_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int GW = $clog2(BUSY_GUARD + 1);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [IW-1:0]    r_ptr;
  logic             r_lock;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_req_ready;
  logic             r_tx_dv;
  logic [7:0]       r_tx_byte;
  logic             r_tx_err;
  logic [LW-1:0]    r_lock_cnt;
  logic [GW-1:0]    r_guard_cnt;

  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_win_oh;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_any;
  logic [7:0]       w_win_byte;
  logic             w_win_last;
  logic             w_issue;
  logic             w_lock_idle;
  logic             w_lock_expire;
  logic             w_tx_fell;
  logic             w_guard_expire;

  // While locked, the grant register is the one-hot of the owner, so it doubles as the candidate mask.
  assign w_cand = r_lock ? (i_req_valid & r_grant) : i_req_valid;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req    (w_cand),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  // State register; reset lands in ARB, which still waits for the un-reset transmitter to go idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_ARB;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_ARB:       if (w_issue) w_next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (w_tx_fell)           w_next_state = ST_WAIT_IDLE;
        else if (w_guard_expire) w_next_state = ST_ARB;
      end
      ST_WAIT_IDLE: if (i_tx_done) w_next_state = ST_ARB;
      default:      w_next_state = ST_ARB;
    endcase
  end

  // Decode of winner data and per-state events that drive the datapath registers.
  always_comb begin
    w_win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) w_win_byte = i_req_byte[8*i +: 8];
    end
    w_win_last     = |(w_win_oh & i_req_last);
    w_issue        = (r_state == ST_ARB) && i_tx_done && w_win_any;
    w_lock_idle    = (r_state == ST_ARB) && r_lock && i_tx_done && !(|(i_req_valid & r_grant));
    w_lock_expire  = w_lock_idle && (r_lock_cnt == LW'(LOCK_TIMEOUT - 1));
    w_tx_fell      = (r_state == ST_WAIT_BUSY) && !i_tx_done;
    w_guard_expire = (r_state == ST_WAIT_BUSY) && i_tx_done &&
                     (r_guard_cnt == GW'(BUSY_GUARD - 1));
  end

  // Datapath: issue strobe, grant/lock bookkeeping, lock timeout and busy guard counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr       <= IW'(N_REQ - 1);
      r_lock      <= 1'b0;
      r_grant     <= '0;
      r_req_ready <= '0;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_tx_err    <= 1'b0;
      r_lock_cnt  <= '0;
      r_guard_cnt <= '0;
    end else begin
      r_tx_dv     <= 1'b0;
      r_req_ready <= '0;
      if (w_issue) begin
        r_tx_dv     <= 1'b1;
        r_tx_byte   <= w_win_byte;
        r_req_ready <= w_win_oh;
        r_grant     <= w_win_oh;
        r_ptr       <= w_win_idx;
        r_lock      <= ~w_win_last;
        r_lock_cnt  <= '0;
        r_guard_cnt <= '0;
      end else if (w_lock_expire) begin
        // Owner went quiet mid-packet: free the line; pointer stays so RR resumes after it.
        r_lock     <= 1'b0;
        r_grant    <= '0;
        r_lock_cnt <= '0;
      end else if (w_lock_idle) begin
        r_lock_cnt <= r_lock_cnt + LW'(1);
      end
      if (r_state == ST_WAIT_BUSY) begin
        if (w_tx_fell) begin
          r_guard_cnt <= '0;
          if (!r_lock) r_grant <= '0;
        end else if (w_guard_expire) begin
          r_tx_err    <= 1'b1;
          r_lock      <= 1'b0;
          r_grant     <= '0;
          r_guard_cnt <= '0;
        end else begin
          r_guard_cnt <= r_guard_cnt + GW'(1);
        end
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_grant     = r_grant;
  assign o_tx_dv     = r_tx_dv;
  assign o_tx_byte   = r_tx_byte;
  assign o_busy      = (r_state != ST_ARB);
  assign o_tx_err    = r_tx_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural 8N1 transmitter (4 clocks per bit).
// Bytes decoded from the line are checked against an expected-byte queue.
// Requesters are queue-driven and hold VALID until REQ_READY.
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int LOCK_TIMEOUT = 1200;
  localparam int BUSY_GUARD   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_byte;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_grant;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic        tx_done;
  logic        o_busy;
  logic        o_tx_err;
  logic        stub = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] req_q [4][$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .BUSY_GUARD   (BUSY_GUARD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_byte  (req_byte),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
    .i_tx_done   (tx_done),
    .o_busy      (o_busy),
    .o_tx_err    (o_tx_err)
  );

  // Behavioural transmitter: no reset, start bit, 8 data LSB first, stop bit.
  logic       m_busy = 1'b0;
  logic [9:0] m_frame = 10'h3FF;
  logic [1:0] m_sub = 2'd0;
  logic [3:0] m_bitn = 4'd0;
  logic       line;
  assign line    = m_busy ? m_frame[0] : 1'b1;
  assign tx_done = stub ? 1'b1 : !m_busy;

  always @(posedge clk) begin
    if (!m_busy) begin
      if (o_tx_dv && !stub) begin
        m_busy  <= 1'b1;
        m_frame <= {1'b1, o_tx_byte, 1'b0};
        m_sub   <= 2'd0;
        m_bitn  <= 4'd0;
      end
    end else begin
      m_sub <= m_sub + 2'd1;
      if (m_sub == 2'd3) begin
        m_frame <= {1'b1, m_frame[9:1]};
        if (m_bitn == 4'd9) m_busy <= 1'b0;
        else                m_bitn <= m_bitn + 4'd1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Requester driver: after each edge, retire accepted bytes and present the queue heads.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (o_req_ready[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        if (req_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_last[i]        = req_q[i][0][8];
          req_byte[8*i +: 8] = req_q[i][0][7:0];
        end else begin
          req_valid[i]       = 1'b0;
          req_last[i]        = 1'b0;
          req_byte[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // Line receiver feeding the scoreboard.
  logic rx_active = 1'b0;
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (line === 1'b0) begin
        rx_active = 1'b1;
        d = 8'h00;
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          d[b] = line;
        end
        repeat (4) @(negedge clk);
        check("rx_stop_bit", {31'd0, line}, 32'd1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got byte %h, expected none", d);
        end else begin
          check("rx_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
        rx_active = 1'b0;
      end
    end
  end

  // Every strobe must find the transmitter idle and carry exactly one READY matching GRANT.
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_dv && !stub) begin
        check("dv_tx_idle", {31'd0, m_busy}, 32'd0);
        check("dv_ready_eq_grant", {28'd0, o_req_ready}, {28'd0, o_grant});
        check("dv_ready_onehot", {31'd0, $onehot(o_req_ready)}, 32'd1);
      end
    end
  end

  function automatic bit all_idle();
    return exp_q.size() == 0 && !m_busy && !o_busy && !rx_active &&
           req_q[0].size() == 0 && req_q[1].size() == 0 &&
           req_q[2].size() == 0 && req_q[3].size() == 0;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int c = 0;
    while (!all_idle() && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_idle_timeout"}, {31'd0, all_idle()}, 32'd1);
  endtask

  task automatic wait_dv(input string nm, input int budget);
    int c = 0;
    while (!o_tx_dv && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_dv_timeout"}, {31'd0, o_tx_dv}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          do_rst;
    logic [3:0]  valid;
    logic [31:0] bytes;
    int          n;
    logic [31:0] order;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cnt;
    // Single-byte packets (LAST=1); order is the expected line order, first byte in [7:0].
    vecs[0] = '{1'b1, 4'b1111, 32'hA3A2A1A0, 4, 32'hA3A2A1A0};
    vecs[1] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 4, 32'hA3A2A1A0};
    vecs[2] = '{1'b0, 4'b0101, 32'h00720070, 2, 32'h00007270};
    vecs[3] = '{1'b0, 4'b1010, 32'h83008100, 2, 32'h00008183};
    vecs[4] = '{1'b0, 4'b1001, 32'h93000090, 2, 32'h00009093};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, o_busy},   32'd0);
    check("rst_grant", {28'd0, o_grant},  32'd0);
    check("rst_ready", {28'd0, o_req_ready}, 32'd0);
    check("rst_dv",    {31'd0, o_tx_dv},  32'd0);
    check("rst_byte",  {24'd0, o_tx_byte}, 32'd0);
    check("rst_err",   {31'd0, o_tx_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request: one-cycle latency, single READY pulse.
    req_q[0].push_back({1'b1, 8'h41});
    exp_q.push_back(8'h41);
    @(negedge clk);
    check("t1_valid_seen", {28'd0, req_valid}, 32'h1);
    check("t1_no_dv_yet",  {31'd0, o_tx_dv},  32'd0);
    @(negedge clk);
    check("t1_dv",    {31'd0, o_tx_dv},   32'd1);
    check("t1_byte",  {24'd0, o_tx_byte}, 32'h41);
    check("t1_ready", {28'd0, o_req_ready}, 32'h1);
    check("t1_busy",  {31'd0, o_busy},    32'd1);
    @(negedge clk);
    check("t1_dv_pulse",    {31'd0, o_tx_dv}, 32'd0);
    check("t1_ready_pulse", {28'd0, o_req_ready}, 32'h0);
    wait_idle("t1", 500);

    // Table of simultaneous single-byte requests.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_rst) do_reset();
      for (int i = 0; i < 4; i++) begin
        if (vecs[v].valid[i]) req_q[i].push_back({1'b1, vecs[v].bytes[8*i +: 8]});
      end
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].order[8*k +: 8]);
      wait_idle($sformatf("vec%0d", v), 1500);
      check($sformatf("vec%0d_grant_free", v), {28'd0, o_grant}, 32'd0);
    end

    // Locked 3-byte packet on req1 while req0/req2 wait (pointer is at 0 here).
    req_q[1].push_back({1'b0, 8'hC1});
    req_q[1].push_back({1'b0, 8'hC2});
    req_q[1].push_back({1'b1, 8'hC3});
    req_q[0].push_back({1'b1, 8'hD0});
    req_q[2].push_back({1'b1, 8'hE2});
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    exp_q.push_back(8'hE2); exp_q.push_back(8'hD0);
    wait_idle("t3", 2000);

    // Lock timeout: req3 opens a packet and goes quiet; req0 must wait LOCK_TIMEOUT ARB cycles.
    req_q[3].push_back({1'b0, 8'hF3});
    req_q[0].push_back({1'b1, 8'hF0});
    exp_q.push_back(8'hF3);
    exp_q.push_back(8'hF0);
    wait_dv("t4_first", 50);
    check("t4_first_ready", {28'd0, o_req_ready}, 32'h8);
    cnt = 0;
    while (o_busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("t4_locked_grant", {28'd0, o_grant}, 32'h8);
    cnt = 0;
    while (o_grant == 4'b1000 && !o_busy && cnt < LOCK_TIMEOUT + 50) begin
      cnt++;
      @(negedge clk);
    end
    check("t4_block_cycles", cnt, LOCK_TIMEOUT);
    check("t4_grant_free", {28'd0, o_grant}, 32'h0);
    check("t4_no_dv", {31'd0, o_tx_dv}, 32'd0);
    @(negedge clk);
    check("t4_req0_dv",    {31'd0, o_tx_dv}, 32'd1);
    check("t4_req0_grant", {28'd0, o_grant}, 32'h1);
    wait_idle("t4", 500);

    // Transmitter never goes busy: guard expiry raises sticky error.
    stub = 1'b1;
    req_q[2].push_back({1'b1, 8'h99});
    wait_dv("t5", 50);
    cnt = 0;
    while (o_busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_guard_cycles", cnt, BUSY_GUARD);
    check("t5_err",   {31'd0, o_tx_err}, 32'd1);
    check("t5_grant", {28'd0, o_grant},  32'd0);
    repeat (3) @(negedge clk);
    check("t5_err_sticky", {31'd0, o_tx_err}, 32'd1);
    stub = 1'b0;
    do_reset();
    check("t5_err_cleared", {31'd0, o_tx_err}, 32'd0);

    // Reset mid-frame: in-flight byte completes, next issue waits for transmitter idle.
    req_q[1].push_back({1'b1, 8'h5A});
    req_q[2].push_back({1'b1, 8'h6B});
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h6B);
    wait_dv("t6_first", 50);
    check("t6_first_byte", {24'd0, o_tx_byte}, 32'h5A);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_busy",  {31'd0, o_busy},  32'd0);
    check("t6_rst_grant", {28'd0, o_grant}, 32'd0);
    check("t6_rst_dv",    {31'd0, o_tx_dv}, 32'd0);
    check("t6_rst_byte",  {24'd0, o_tx_byte}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_frame_in_flight", {31'd0, m_busy}, 32'd1);
    wait_dv("t6_second", 200);
    check("t6_second_tx_idle", {31'd0, m_busy}, 32'd0);
    check("t6_second_byte", {24'd0, o_tx_byte}, 32'h6B);
    wait_idle("t6", 500);

    check("final_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
